// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster constants shared by the sync generator and the colour stage.
package vga_timing_pkg;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int SCREEN_W = H_DISPLAY;
    localparam int SCREEN_H = V_DISPLAY;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] coord_t;

    // Half-open interval test lo <= pos < hi, done in int so hi may equal 1024.
    function automatic logic in_window(input coord_t pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) < hi);
    endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the sync generator to the colour stage and VGA connector.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_tick;

    modport master (output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick);
    modport slave  (input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick);
endinterface

// File: rtl/tick_divider.sv
// One-clk-wide enable every CLK_DIV clocks; a constant 1 when CLK_DIV is 1.
module tick_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                div_cnt <= '0;
        else if (div_cnt == LAST) div_cnt <= '0;
        else                      div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == LAST);
endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel enable, x/y counters, registered syncs and frame pulse.
module vga_sync_gen
    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::in_window;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic           clk,
    input  logic           rstn,
    vga_sync_gen_if.master vga
);
    localparam int     H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int     HS_START = H_DISPLAY + H_FRONT;
    localparam int     HS_END   = HS_START + H_SYNC;
    localparam int     VS_START = V_DISPLAY + V_FRONT;
    localparam int     VS_END   = VS_START + V_SYNC;
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
            $error("vga_sync_gen: H/V totals must be <= 1024 and CLK_DIV >= 1");
        end
    endgenerate

    logic   p_tick;
    coord_t x_q, y_q;
    coord_t x_nxt, y_nxt;
    logic   hsync_q, vsync_q;

    tick_divider #(.CLK_DIV(CLK_DIV)) u_tick_divider (
        .clk  (clk),
        .rstn (rstn),
        .tick (p_tick)
    );

    always_comb begin
        x_nxt = x_q + 1'b1;
        y_nxt = y_q;
        if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
        end
    end

    // Syncs are decoded from the next-state counters so they change on the same edge as x/y.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else if (p_tick) begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            hsync_q <= in_window(x_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_q <= in_window(y_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vga.p_tick     = p_tick;
    assign vga.pixel_x    = x_q;
    assign vga.pixel_y    = y_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = in_window(x_q, 0, H_DISPLAY) && in_window(y_q, 0, V_DISPLAY);
    assign vga.frame_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: default 640x480 raster, a compact active-high CLK_DIV=1 raster,
// and a compact CLK_DIV=3 raster that takes an asynchronous reset mid-frame.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    typedef struct {
        int          k;
        logic [24:0] v;
        string       name;
    } exp_t;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic rstn_c = 1'b0;
    always #5 clk = ~clk;

    vga_sync_gen_if va();
    vga_sync_gen_if vb();
    vga_sync_gen_if vc();

    vga_sync_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .rstn(rstn), .vga(va));

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b1)
    ) dut_b (.clk(clk), .rstn(rstn), .vga(vb));

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b0)
    ) dut_c (.clk(clk), .rstn(rstn_c), .vga(vc));

    logic [24:0] vec [3];
    assign vec[0] = {va.p_tick, va.pixel_x, va.pixel_y, va.hsync, va.vsync, va.video_on, va.frame_tick};
    assign vec[1] = {vb.p_tick, vb.pixel_x, vb.pixel_y, vb.hsync, vb.vsync, vb.video_on, vb.frame_tick};
    assign vec[2] = {vc.p_tick, vc.pixel_x, vc.pixel_y, vc.hsync, vc.vsync, vc.video_on, vc.frame_tick};

    exp_t sb [3][$];
    int   ka, kb, kc;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   a_hs_low = 0, b_vs_act = 0, b_vis = 0, b_ft = 0, b_pt_low = 0;

    // Clock edges seen since the last reset release, per instance.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin ka <= 0; kb <= 0; end
        else       begin ka <= ka + 1; kb <= kb + 1; end
    end
    always @(posedge clk or negedge rstn_c) begin
        if (!rstn_c) kc <= 0;
        else         kc <= kc + 1;
    end

    function automatic exp_t mk(int k, int pt, int x, int y, int hs, int vs, int von, int ft, string nm);
        exp_t e;
        e.k    = k;
        e.v    = {1'(pt), 10'(x), 10'(y), 1'(hs), 1'(vs), 1'(von), 1'(ft)};
        e.name = nm;
        return e;
    endfunction

    function automatic string fmt(logic [24:0] v);
        return $sformatf("pt=%b x=%0d y=%0d hs=%b vs=%b von=%b ft=%b",
                         v[24], v[23:14], v[13:4], v[3], v[2], v[1], v[0]);
    endfunction

    task automatic check(string nm, logic [24:0] act, logic [24:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %s, required %s", nm, fmt(act), fmt(req));
    endtask

    task automatic check_int(string nm, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    // Monitor: compare the queue head when its instance reaches the expected cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int cur;
            cur = (d == 0) ? ka : (d == 1) ? kb : kc;
            if (sb[d].size() > 0) begin
                if (sb[d][0].k == cur) begin
                    check(sb[d][0].name, vec[d], sb[d][0].v);
                    void'(sb[d].pop_front());
                end else if (sb[d][0].k < cur) begin
                    n_chk++;
                    $display("FAIL %s: sample cycle %0d skipped, instance at cycle %0d",
                             sb[d][0].name, sb[d][0].k, cur);
                    void'(sb[d].pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && ka < 1600 && !va.hsync) a_hs_low++;
        if (rstn && kb >= 176 && kb < 352) begin
            if (vb.vsync)    b_vs_act++;
            if (vb.video_on) b_vis++;
        end
        if (rstn && kb < 352 && vb.frame_tick) b_ft++;
        if (rstn && !vb.p_tick) b_pt_low++;
    end

    initial begin
        int waited;
        //                 k    pt  x    y  hs vs von ft
        sb[0].push_back(mk(0,    0, 0,   0, 1, 1, 1, 0, "a_reset"));
        sb[0].push_back(mk(1,    1, 0,   0, 1, 1, 1, 0, "a_first_tick"));
        sb[0].push_back(mk(2,    0, 1,   0, 1, 1, 1, 0, "a_x1"));
        sb[0].push_back(mk(4,    0, 2,   0, 1, 1, 1, 0, "a_x2"));
        sb[0].push_back(mk(1279, 1, 639, 0, 1, 1, 1, 0, "a_last_visible"));
        sb[0].push_back(mk(1280, 0, 640, 0, 1, 1, 0, 0, "a_x640_blank"));
        sb[0].push_back(mk(1311, 1, 655, 0, 1, 1, 0, 0, "a_before_hsync"));
        sb[0].push_back(mk(1312, 0, 656, 0, 0, 1, 0, 0, "a_hsync_start"));
        sb[0].push_back(mk(1503, 1, 751, 0, 0, 1, 0, 0, "a_hsync_last"));
        sb[0].push_back(mk(1504, 0, 752, 0, 1, 1, 0, 0, "a_hsync_end"));
        sb[0].push_back(mk(1599, 1, 799, 0, 1, 1, 0, 0, "a_line_end"));
        sb[0].push_back(mk(1600, 0, 0,   1, 1, 1, 1, 0, "a_line_wrap"));

        sb[1].push_back(mk(0,   1, 0,  0,  0, 0, 1, 0, "b_reset"));
        sb[1].push_back(mk(7,   1, 7,  0,  0, 0, 1, 0, "b_x7_visible"));
        sb[1].push_back(mk(8,   1, 8,  0,  0, 0, 0, 0, "b_x8_blank"));
        sb[1].push_back(mk(9,   1, 9,  0,  0, 0, 0, 0, "b_before_hsync"));
        sb[1].push_back(mk(10,  1, 10, 0,  1, 0, 0, 0, "b_hsync_start"));
        sb[1].push_back(mk(12,  1, 12, 0,  1, 0, 0, 0, "b_hsync_last"));
        sb[1].push_back(mk(13,  1, 13, 0,  0, 0, 0, 0, "b_hsync_end"));
        sb[1].push_back(mk(16,  1, 0,  1,  0, 0, 1, 0, "b_line_wrap"));
        sb[1].push_back(mk(87,  1, 7,  5,  0, 0, 1, 0, "b_corner_visible"));
        sb[1].push_back(mk(96,  1, 0,  6,  0, 0, 0, 0, "b_update_point"));
        sb[1].push_back(mk(111, 1, 15, 6,  0, 0, 0, 0, "b_before_vsync"));
        sb[1].push_back(mk(112, 1, 0,  7,  0, 1, 0, 0, "b_vsync_start"));
        sb[1].push_back(mk(143, 1, 15, 8,  0, 1, 0, 0, "b_vsync_last"));
        sb[1].push_back(mk(144, 1, 0,  9,  0, 0, 0, 0, "b_vsync_end"));
        sb[1].push_back(mk(175, 1, 15, 10, 0, 0, 0, 1, "b_frame_tick"));
        sb[1].push_back(mk(176, 1, 0,  0,  0, 0, 1, 0, "b_frame_wrap"));

        sb[2].push_back(mk(0,   0, 0,  0, 1, 1, 1, 0, "c_reset"));
        sb[2].push_back(mk(2,   1, 0,  0, 1, 1, 1, 0, "c_first_tick"));
        sb[2].push_back(mk(3,   0, 1,  0, 1, 1, 1, 0, "c_x1"));
        sb[2].push_back(mk(30,  0, 10, 0, 0, 1, 0, 0, "c_hsync_start"));
        sb[2].push_back(mk(38,  1, 12, 0, 0, 1, 0, 0, "c_hsync_last"));
        sb[2].push_back(mk(39,  0, 13, 0, 1, 1, 0, 0, "c_hsync_end"));
        sb[2].push_back(mk(288, 0, 0,  6, 1, 1, 0, 0, "c_update_point"));
        sb[2].push_back(mk(336, 0, 0,  7, 1, 0, 0, 0, "c_vsync_start"));
        sb[2].push_back(mk(350, 1, 4,  7, 1, 0, 0, 0, "c_before_reset"));

        repeat (2) @(negedge clk);
        #2;
        rstn   = 1'b1;
        rstn_c = 1'b1;

        waited = 0;
        while (kc != 350 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (kc != 350) begin
            n_chk++;
            $display("FAIL c_reach_midframe: instance at cycle %0d, required 350", kc);
        end

        // Mid-frame reset must take effect without a clock edge.
        #2;
        rstn_c = 1'b0;
        #1;
        check("c_async_reset", vec[2], mk(0, 0, 0, 0, 1, 1, 1, 0, "").v);
        sb[2].push_back(mk(0,  0, 0, 0, 1, 1, 1, 0, "c_reset_held"));
        sb[2].push_back(mk(5,  1, 1, 0, 1, 1, 1, 0, "c_restart_x1"));
        sb[2].push_back(mk(48, 0, 0, 1, 1, 1, 1, 0, "c_restart_line"));
        repeat (2) @(negedge clk);
        #2;
        rstn_c = 1'b1;

        waited = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() != 0) && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        for (int d = 0; d < 3; d++) begin
            while (sb[d].size() > 0) begin
                n_chk++;
                $display("FAIL %s: never reached within cycle budget", sb[d][0].name);
                void'(sb[d].pop_front());
            end
        end
        @(negedge clk);

        check_int("a_hsync_low_clks", a_hs_low, 192);
        check_int("b_vsync_active_clks", b_vs_act, 32);
        check_int("b_visible_per_frame", b_vis, 48);
        check_int("b_frame_ticks_two_frames", b_ft, 2);
        check_int("b_p_tick_low_clks", b_pt_low, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
